// File: rtl/move_decoder.sv
// -----------------------------------------------------------------------------
// move_decoder
// Turns a stream of PS/2 set-2 scan bytes into a live pressed-key mask. On each
// frame boundary it also produces a single latched move code.
//
// Ports
//   clk           system clock (CLOCK_50 domain)
//   reset         asynchronous active-high reset
//   rx_done_tick  one-cycle strobe from ps2_rx; rx_data is valid in that cycle
//   rx_data       PS/2 set-2 scan byte
//   frame_tick    one-cycle strobe at the 60 Hz frame boundary
//   move          frame-latched move code: 0 none, 1 up, 2 down, 3 left,
//                 4 right, 5 action
//   move_valid    one-cycle pulse in the cycle after frame_tick
//   held          live pressed-key mask {action,right,left,down,up}
// -----------------------------------------------------------------------------
module move_decoder #(
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       frame_tick,
    output logic [2:0] move,
    output logic       move_valid,
    output logic [4:0] held
);

    localparam int TW = (PREFIX_TIMEOUT < 1) ? 1 : $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(PREFIX_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Maps a plain (unprefixed) code to a one-hot key {action,right,left,down,up}.
    function automatic logic [4:0] plain_map(input logic [7:0] code);
        case (code)
            8'h1D:   plain_map = 5'b00001;
            8'h1B:   plain_map = 5'b00010;
            8'h1C:   plain_map = 5'b00100;
            8'h23:   plain_map = 5'b01000;
            8'h29:   plain_map = 5'b10000;
            default: plain_map = 5'b00000;
        endcase
    endfunction

    // Maps an E0-prefixed code (the arrow keys) to a one-hot key.
    function automatic logic [4:0] ext_map(input logic [7:0] code);
        case (code)
            8'h75:   ext_map = 5'b00001;
            8'h72:   ext_map = 5'b00010;
            8'h6B:   ext_map = 5'b00100;
            8'h74:   ext_map = 5'b01000;
            default: ext_map = 5'b00000;
        endcase
    endfunction

    // Priority encoder: up > down > left > right > action.
    function automatic logic [2:0] move_encode(input logic [4:0] keys);
        if (keys[0]) begin
            move_encode = 3'd1;
        end else if (keys[1]) begin
            move_encode = 3'd2;
        end else if (keys[2]) begin
            move_encode = 3'd3;
        end else if (keys[3]) begin
            move_encode = 3'd4;
        end else if (keys[4]) begin
            move_encode = 3'd5;
        end else begin
            move_encode = 3'd0;
        end
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [TW-1:0]   timer_r;
    logic            timeout_s;
    logic [4:0]      make_mask_s;
    logic [4:0]      break_mask_s;
    logic [4:0]      held_r;
    logic [4:0]      tap_r;
    logic [2:0]      move_r;
    logic            move_valid_r;

    // A prefix state gives up only when a full timeout elapses with no byte arriving.
    assign timeout_s = (state_r != ST_IDLE) && !rx_done_tick && (timer_r == TIMEOUT_LIMIT);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic: prefixes advance, and every other byte returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = ST_IDLE;
        end else if (rx_done_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_s = ST_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_s = ST_BRK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_s = ST_EXT_BRK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BRK:     state_s = ST_IDLE;
                ST_EXT_BRK: state_s = ST_IDLE;
                default:    state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM outputs: one-hot make/break masks for the byte that completes a sequence.
    // The E0 and F0 bytes map to nothing, so they produce no mask in IDLE or EXT.
    always_comb begin
        make_mask_s  = 5'b00000;
        break_mask_s = 5'b00000;
        if (rx_done_tick) begin
            case (state_r)
                ST_IDLE:    make_mask_s  = plain_map(rx_data);
                ST_EXT:     make_mask_s  = ext_map(rx_data);
                ST_BRK:     break_mask_s = plain_map(rx_data);
                ST_EXT_BRK: break_mask_s = ext_map(rx_data);
                default: begin
                    make_mask_s  = 5'b00000;
                    break_mask_s = 5'b00000;
                end
            endcase
        end else begin
            make_mask_s  = 5'b00000;
            break_mask_s = 5'b00000;
        end
    end

    // Prefix timeout counter: it is held at zero in IDLE, cleared on every byte, and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= '0;
        end else if ((state_s == ST_IDLE) || rx_done_tick) begin
            timer_r <= '0;
        end else if (timer_r != TIMEOUT_LIMIT) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Key masks: held tracks make/break. tap remembers any make since the last frame,
    // so a quick press-and-release still yields one frame of movement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_r <= 5'b00000;
            tap_r  <= 5'b00000;
        end else begin
            held_r <= (held_r | make_mask_s) & ~break_mask_s;
            if (frame_tick) begin
                // A make that coincides with the frame belongs to the next frame.
                tap_r <= make_mask_s;
            end else begin
                tap_r <= tap_r | make_mask_s;
            end
        end
    end

    // Frame latch: it samples the masks as they were before this cycle's byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_r       <= 3'd0;
            move_valid_r <= 1'b0;
        end else begin
            move_valid_r <= frame_tick;
            if (frame_tick) begin
                move_r <= move_encode(held_r | tap_r);
            end else begin
                move_r <= move_r;
            end
        end
    end

    assign move       = move_r;
    assign move_valid = move_valid_r;
    assign held       = held_r;

endmodule

// File: tb/tb_move_decoder.sv
module tb_move_decoder;

    localparam int PT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frame_tick = 1'b0;
    logic [2:0] move;
    logic       move_valid;
    logic [4:0] held;

    move_decoder #(.PREFIX_TIMEOUT(PT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .frame_tick   (frame_tick),
        .move         (move),
        .move_valid   (move_valid),
        .held         (held)
    );

    always #5 clk = ~clk;

    // Scoreboard queues. Expected moves are consumed whenever move_valid is seen.
    // Direct checks (kind 0 held, 1 move, 2 move_valid, 3 leftover moves) are
    // evaluated at the next falling edge.
    int          exp_move_q[$];
    string       chk_name_q[$];
    int          chk_kind_q[$];
    int          chk_exp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int move_idx = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        if (move_valid === 1'b1) begin
            chk("move_valid_one_cycle", int'(prev_valid), 0);
            if (exp_move_q.size() == 0) begin
                chk("unexpected_move_valid", 1, 0);
            end else begin
                chk($sformatf("move_frame%0d", move_idx), int'(move), exp_move_q.pop_front());
            end
            move_idx++;
        end
        prev_valid = move_valid;
        while (chk_kind_q.size() > 0) begin
            string nm;
            int    kd;
            int    ex;
            nm = chk_name_q.pop_front();
            kd = chk_kind_q.pop_front();
            ex = chk_exp_q.pop_front();
            case (kd)
                0:       chk(nm, int'(held), ex);
                1:       chk(nm, int'(move), ex);
                2:       chk(nm, int'(move_valid), ex);
                default: chk(nm, exp_move_q.size(), ex);
            endcase
        end
    end

    task automatic expect_direct(input string nm, input int kd, input int ex);
        chk_name_q.push_back(nm);
        chk_kind_q.push_back(kd);
        chk_exp_q.push_back(ex);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic frame(input int exp);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        exp_move_q.push_back(exp);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // A byte strobe that lands in the same cycle as frame_tick.
    task automatic frame_with_byte(input logic [7:0] b, input int exp);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        rx_data = b;
        rx_done_tick = 1'b1;
        exp_move_q.push_back(exp);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        rx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_direct("reset_held", 0, 0);
        expect_direct("reset_move", 1, 0);
        expect_direct("reset_move_valid", 2, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single plain make of up
        send(8'h1D);
        expect_direct("up_make_held", 0, 5'b00001);
        frame(1);
        send(8'hF0); send(8'h1D);
        expect_direct("up_break_held", 0, 5'b00000);
        frame(0);

        // Extended right: make, then extended break
        send(8'hE0); send(8'h74);
        expect_direct("ext_right_held", 0, 5'b01000);
        frame(4);
        send(8'hE0); send(8'hF0); send(8'h74);
        expect_direct("ext_right_break_held", 0, 5'b00000);
        frame(0);

        // Action tapped within one frame: exactly one frame of move code 5
        send(8'h29); send(8'hF0); send(8'h29);
        expect_direct("action_tap_held", 0, 5'b00000);
        frame(5);
        frame(0);

        // Priority between left and up
        send(8'h1C); send(8'h1D);
        expect_direct("left_up_held", 0, 5'b00101);
        frame(1);
        send(8'hF0); send(8'h1D);
        expect_direct("left_only_held", 0, 5'b00100);
        frame(3);
        send(8'hF0); send(8'h1C);
        frame(0);

        // Typematic repeats of down, then release
        send(8'h1B); send(8'h1B); send(8'h1B);
        expect_direct("typematic_held", 0, 5'b00010);
        send(8'hF0); send(8'h1B);
        expect_direct("down_break_held", 0, 5'b00000);
        frame(2);
        frame(0);

        // Breaks of unheld keys and an unmapped byte have no effect
        send(8'hF0); send(8'h23);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h12);
        expect_direct("noop_held", 0, 5'b00000);
        frame(0);

        // Extended left, and a plain code after E0 is ignored
        send(8'hE0); send(8'h1D);
        expect_direct("ext_unmapped_held", 0, 5'b00000);
        send(8'hE0); send(8'h6B);
        expect_direct("ext_left_held", 0, 5'b00100);
        send(8'hE0); send(8'hF0); send(8'h6B);
        frame(3);

        // A byte arriving before the timeout still completes the extended code
        send(8'hE0);
        repeat (PT - 5) @(posedge clk);
        send(8'h75);
        expect_direct("before_timeout_held", 0, 5'b00001);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_direct("before_timeout_break", 0, 5'b00000);
        frame(1);

        // E0 times out, so the following 75 is a plain unmapped byte
        send(8'hE0);
        repeat (PT + 5) @(posedge clk);
        send(8'h75);
        expect_direct("ext_timeout_held", 0, 5'b00000);
        frame(0);

        // F0 times out, so the following 1D is a make rather than a break
        send(8'h1D);
        send(8'hF0);
        repeat (PT + 5) @(posedge clk);
        send(8'h1D);
        expect_direct("brk_timeout_held", 0, 5'b00001);
        send(8'hF0); send(8'h1D);
        frame(1);
        frame(0);

        // A make coincident with frame_tick counts toward the next frame
        frame_with_byte(8'h23, 0);
        expect_direct("coincident_held", 0, 5'b01000);
        frame(4);

        // Reset in the middle of an extended sequence
        send(8'hE0);
        #2;
        reset = 1'b1;
        expect_direct("midreset_held", 0, 0);
        expect_direct("midreset_move", 1, 0);
        expect_direct("midreset_move_valid", 2, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(8'h75);
        expect_direct("post_reset_plain75_held", 0, 5'b00000);
        send(8'h1D);
        expect_direct("post_reset_up_held", 0, 5'b00001);
        frame(1);

        expect_direct("no_missing_move_valid", 3, 0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
